// File: rtl/lc3b_types.sv
// Shared types for the L1-to-L2 memory path: word/line widths, the
// arbiter client identifiers and states, and the round-robin pick helper.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_c_line;

  // Which L1 client owns (or last owned) the L2 port.
  typedef enum logic {
    ARB_I = 1'b0,
    ARB_D = 1'b1
  } arb_client_t;

  // Arbiter states: free, or holding the L2 port for one client.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_t;

  // Round-robin pick: a lone requester wins; on contention the client
  // that was not served last wins. Only meaningful when a request exists.
  function automatic arb_client_t rr_pick(input logic req_i,
                                          input logic req_d,
                                          input arb_client_t last);
    arb_client_t pick;
    if (req_i && req_d) begin
      pick = (last == ARB_I) ? ARB_D : ARB_I;
    end else if (req_i) begin
      pick = ARB_I;
    end else begin
      pick = ARB_D;
    end
    return pick;
  endfunction

endpackage

// File: rtl/l1_arbiter.sv
// l1_arbiter: merges the I-cache and D-cache physical-memory ports into a
// single request port toward L2. One client owns the port from grant until
// the L2 completion pulse; contention is resolved round-robin. The request
// (op, address, write line) is captured at grant so L2 sees stable values
// regardless of what the L1 drives afterwards.
module l1_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH = $bits(lc3b_word),
  parameter int LINE_WIDTH = $bits(lc3b_c_line)
) (
  input  logic                  clk,
  input  logic                  reset,
  // I-cache side
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [ADDR_WIDTH-1:0] i_address,
  input  logic [LINE_WIDTH-1:0] i_wdata,
  output logic                  i_resp,
  output logic [LINE_WIDTH-1:0] i_rdata,
  // D-cache side
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic                  d_resp,
  output logic [LINE_WIDTH-1:0] d_rdata,
  // L2 side
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [ADDR_WIDTH-1:0] l2_address,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  input  logic                  l2_resp,
  input  logic [LINE_WIDTH-1:0] l2_rdata
);

  arb_state_t              state_q,      state_d;
  arb_client_t             last_grant_q, last_grant_d;
  logic                    l2_read_q,    l2_read_d;
  logic                    l2_write_q,   l2_write_d;
  logic [ADDR_WIDTH-1:0]   l2_address_q, l2_address_d;
  logic [LINE_WIDTH-1:0]   l2_wdata_q,   l2_wdata_d;

  logic                    req_i;
  logic                    req_d;
  arb_client_t             grantee;

  // Request detection and round-robin choice among the current requesters.
  always_comb begin
    req_i   = i_read | i_write;
    req_d   = d_read | d_write;
    grantee = rr_pick(req_i, req_d, last_grant_q);
  end

  // Next-state: grant and capture in IDLE, hold while busy, release on L2 completion.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    l2_read_d    = l2_read_q;
    l2_write_d   = l2_write_q;
    l2_address_d = l2_address_q;
    l2_wdata_d   = l2_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_i || req_d) begin
          last_grant_d = grantee;
          if (grantee == ARB_I) begin
            state_d      = ST_BUSY_I;
            // read+write together is illegal; write takes precedence
            l2_write_d   = i_write;
            l2_read_d    = i_read & ~i_write;
            l2_address_d = i_address;
            l2_wdata_d   = i_wdata;
          end else begin
            state_d      = ST_BUSY_D;
            l2_write_d   = d_write;
            l2_read_d    = d_read & ~d_write;
            l2_address_d = d_address;
            l2_wdata_d   = d_wdata;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        // The captured request is held even if the client drops its level.
        if (l2_resp) begin
          state_d    = ST_IDLE;
          l2_read_d  = 1'b0;
          l2_write_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        l2_read_d  = 1'b0;
        l2_write_d = 1'b0;
      end
    endcase
  end

  // Completion routing: only the owning client sees the L2 pulse; rdata fans out to both.
  always_comb begin
    i_resp  = l2_resp && (state_q == ST_BUSY_I);
    d_resp  = l2_resp && (state_q == ST_BUSY_D);
    i_rdata = l2_rdata;
    d_rdata = l2_rdata;
  end

  // State and captured-request registers; reset abandons any in-flight L2 op.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= ARB_D;
      l2_read_q    <= 1'b0;
      l2_write_q   <= 1'b0;
      l2_address_q <= {ADDR_WIDTH{1'b0}};
      l2_wdata_q   <= {LINE_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      l2_read_q    <= l2_read_d;
      l2_write_q   <= l2_write_d;
      l2_address_q <= l2_address_d;
      l2_wdata_q   <= l2_wdata_d;
    end
  end

  assign l2_read    = l2_read_q;
  assign l2_write   = l2_write_q;
  assign l2_address = l2_address_q;
  assign l2_wdata   = l2_wdata_q;

endmodule
